calc1_req_driver: RTL and testbench
===================================

# calc1_req_driver

Transaction-level request driver sitting directly upstream of one calc1 port. Accepts a complete operation (command, operand 1, operand 2) in a single valid/ready handshake, sequences it onto the calc1 two-cycle port protocol, waits for the calc1 response, and returns the result through a held valid/ready response channel. Four instances, one per calc1 port, replace hand-timed stimulus in the calc1 benches and serve as the front end for later traffic generators.

## Interface
Parameters:
- TIMEOUT_CYCLES, 32: WAIT cycles allowed before a missing response is declared a timeout (legal range 4–255).

Ports:
- c_clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request offered.
- req_ready  out  1  driver can accept a request.
- req_cmd  in  [0:3]  calc1 command.
- req_op1  in  [0:31]  operand 1.
- req_op2  in  [0:31]  operand 2.
- port_cmd  out  [0:3]  to calc1 reqN_cmd_in.
- port_data  out  [0:31]  to calc1 reqN_data_in.
- port_resp  in  [0:1]  from calc1 out_respN.
- port_rdata  in  [0:31]  from calc1 out_dataN.
- rsp_valid  out  1  result held for consumer.
- rsp_ready  in  1  consumer takes result.
- rsp_resp  out  [0:1]  captured calc1 response (0 on timeout or null command).
- rsp_data  out  [0:31]  captured calc1 data (0 on timeout, null command, or resp≠1).
- rsp_timeout  out  1  result is a timeout.
- stray_resp  out  1  one-cycle pulse: nonzero port_resp outside WAIT.

## Operation
- States: IDLE, CMD, OPND, WAIT, DONE. All outputs registered.
- IDLE: req_ready=1; port_cmd=0, port_data=0. On req_valid&req_ready: latch request; req_cmd≠0 → CMD; req_cmd=0 → DONE with rsp_resp=0, rsp_data=0, rsp_timeout=0, no port activity.
- CMD (one cycle): port_cmd=latched cmd, port_data=op1. → OPND.
- OPND (one cycle): port_cmd=0, port_data=op2. → WAIT, cycle counter cleared.
- WAIT: port_cmd=0, port_data=0; counter increments each cycle. port_resp≠0 → capture port_resp; capture port_rdata only if port_resp=1, else 0; → DONE. Counter reaching TIMEOUT_CYCLES with port_resp=0 → rsp_timeout=1, rsp_resp=0, rsp_data=0, → DONE. Response and timeout in the same cycle: response wins.
- DONE: rsp_valid=1, rsp_* stable until rsp_valid&rsp_ready, then → IDLE, rsp_valid=0, rsp_timeout=0.
- Commands are not filtered: invalid encodings (3, 4, 7–15) are driven unchanged, and calc1's resp 2 is returned.
- port_resp≠0 in IDLE, CMD, OPND or DONE: ignored for the result; stray_resp pulses the following cycle.

## Timing
- Reset (async assert, sync release): state IDLE; req_ready=1 after release (0 while reset held); port_cmd=0, port_data=0, rsp_valid=0, rsp_resp=0, rsp_data=0, rsp_timeout=0, stray_resp=0, counter=0.
- Accept on edge N → CMD values on port from edge N to N+1; op2 from N+1 to N+2; WAIT from edge N+2.
- A response sampled at edge M → rsp_valid high after edge M. Minimum request-to-rsp_valid latency is 4 cycles when calc1 responds on the first WAIT edge.
- Timeout: rsp_valid rises TIMEOUT_CYCLES edges after WAIT entry.
- Throughput: at most one outstanding request per driver; req_ready=0 from acceptance until the DONE handshake completes. No back-to-back acceptance in the IDLE cycle following DONE.
- Reset mid-operation: operation dropped with no result; any late calc1 response then raises stray_resp.

## Structure
- Shared package calc1_pkg holds:
  - command constants CMD_NOP=0, CMD_ADD=1, CMD_SUB=2, CMD_SHL=5, CMD_SHR=6;
  - response constants RESP_NONE=0, RESP_OK=1, RESP_ERR=2;
  - the driver state enum;
  - data and cmd width constants (32, 4).
- Single module; no sub-module. The timeout counter is inline, with width ceil(log2(TIMEOUT_CYCLES+1)).
- The four-port wrapper is a separate, later block.

## Test plan
- ADD 0x0000_0001 + 0x1FFF_FFFF, rsp_ready=1 → rsp_resp=1, rsp_data=0x2000_0000, rsp_timeout=0. Port shows cmd 1/data 0x1 then cmd 0/data 0x1FFF_FFFF.
- ADD 0xFFFF_FFFF + 0x1, then SUB 0x1 − 0xF → both give rsp_resp=2, rsp_data=0. Invalid cmd 3 → rsp_resp=2.
- SHL 0x1 by 31 → rsp_data=0x8000_0000. SHR 0x8000_0000 by 1 → 0x4000_0000.
- port_resp tied to 0, TIMEOUT_CYCLES=8 → rsp_valid exactly 8 edges after WAIT entry, rsp_timeout=1, rsp_resp=0. A forced port_resp=1 in IDLE → stray_resp pulse, no rsp_valid.
- rsp_ready held low 5 cycles after a result → rsp_* stable, req_ready=0, a second req_valid is not accepted until the handshake completes. Null cmd 0 → DONE with resp 0 and no port activity.
- Reset asserted in WAIT → all outputs at reset values immediately; a calc1 response arriving after release pulses stray_resp, and the next request completes normally.

Source files
------------

// File: rtl/calc1_pkg.sv
// Shared calc1 definitions: command/response encodings,
// bus widths and the request driver state type.
package calc1_pkg;

    localparam int DATA_W = 32;
    localparam int CMD_W  = 4;
    localparam int RESP_W = 2;

    localparam logic [0:CMD_W-1] CMD_NOP = 4'd0;
    localparam logic [0:CMD_W-1] CMD_ADD = 4'd1;
    localparam logic [0:CMD_W-1] CMD_SUB = 4'd2;
    localparam logic [0:CMD_W-1] CMD_SHL = 4'd5;
    localparam logic [0:CMD_W-1] CMD_SHR = 4'd6;

    localparam logic [0:RESP_W-1] RESP_NONE = 2'd0;
    localparam logic [0:RESP_W-1] RESP_OK   = 2'd1;
    localparam logic [0:RESP_W-1] RESP_ERR  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_OPND,
        ST_WAIT,
        ST_DONE
    } drv_state_t;

endpackage

// File: rtl/calc1_req_driver.sv
// Single-port calc1 request driver: one request handshake in,
// two-cycle port sequence out, held response channel back.
module calc1_req_driver
    import calc1_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [0:CMD_W-1]  req_cmd,
    input  logic [0:DATA_W-1] req_op1,
    input  logic [0:DATA_W-1] req_op2,
    output logic [0:CMD_W-1]  port_cmd,
    output logic [0:DATA_W-1] port_data,
    input  logic [0:RESP_W-1] port_resp,
    input  logic [0:DATA_W-1] port_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [0:RESP_W-1] rsp_resp,
    output logic [0:DATA_W-1] rsp_data,
    output logic              rsp_timeout,
    output logic              stray_resp
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    drv_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [0:DATA_W-1] op2_q;

    // Request sequencer: all port and response outputs are registered here.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            op2_q       <= '0;
            req_ready   <= 1'b0;
            port_cmd    <= '0;
            port_data   <= '0;
            rsp_valid   <= 1'b0;
            rsp_resp    <= '0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
            stray_resp  <= 1'b0;
        end else begin
            stray_resp <= (state != ST_WAIT) && (port_resp != RESP_NONE);
            unique case (state)
                ST_IDLE: begin
                    port_cmd  <= '0;
                    port_data <= '0;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        op2_q     <= req_op2;
                        if (req_cmd != CMD_NOP) begin
                            state     <= ST_CMD;
                            port_cmd  <= req_cmd;
                            port_data <= req_op1;
                        end else begin
                            state       <= ST_DONE;
                            rsp_valid   <= 1'b1;
                            rsp_resp    <= RESP_NONE;
                            rsp_data    <= '0;
                            rsp_timeout <= 1'b0;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ST_CMD: begin
                    port_cmd  <= '0;
                    port_data <= op2_q;
                    state     <= ST_OPND;
                end
                ST_OPND: begin
                    port_data <= '0;
                    cnt       <= '0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (port_resp != RESP_NONE) begin
                        rsp_valid   <= 1'b1;
                        rsp_resp    <= port_resp;
                        rsp_data    <= (port_resp == RESP_OK) ? port_rdata : '0;
                        rsp_timeout <= 1'b0;
                        state       <= ST_DONE;
                    end else if (cnt == CNT_LAST) begin
                        rsp_valid   <= 1'b1;
                        rsp_resp    <= RESP_NONE;
                        rsp_data    <= '0;
                        rsp_timeout <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        rsp_timeout <= 1'b0;
                        req_ready   <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc1_req_driver.sv
// Bench for calc1_req_driver: calc1 port stand-in, cycle
// timeline model of the driver, directed literal checks.
module tb_calc1_req_driver;

    localparam int T = 8;

    logic        c_clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [0:3]  req_cmd = '0;
    logic [0:31] req_op1 = '0;
    logic [0:31] req_op2 = '0;
    logic [0:3]  port_cmd;
    logic [0:31] port_data;
    logic [0:1]  port_resp = '0;
    logic [0:31] port_rdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [0:1]  rsp_resp;
    logic [0:31] rsp_data;
    logic        rsp_timeout;
    logic        stray_resp;

    calc1_req_driver #(.TIMEOUT_CYCLES(T)) dut (
        .c_clk      (c_clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cmd    (req_cmd),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .port_cmd   (port_cmd),
        .port_data  (port_data),
        .port_resp  (port_resp),
        .port_rdata (port_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_resp   (rsp_resp),
        .rsp_data   (rsp_data),
        .rsp_timeout(rsp_timeout),
        .stray_resp (stray_resp)
    );

    always #5 c_clk = ~c_clk;

    int n_vec = 0;
    int n_err = 0;

    // calc1 port behaviour: {resp, data}; error data is junk on purpose
    function automatic logic [33:0] calc1_fn(input logic [3:0] c,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [32:0] s;
        logic [33:0] r;
        r = {2'd2, 32'hDEAD_BEEF};
        case (c)
            4'd1: begin
                s = {1'b0, a} + {1'b0, b};
                if (!s[32]) r = {2'd1, s[31:0]};
            end
            4'd2: if (a >= b) r = {2'd1, a - b};
            4'd5: r = {2'd1, a << b[4:0]};
            4'd6: r = {2'd1, a >> b[4:0]};
            default: ;
        endcase
        return r;
    endfunction

    // calc1 stand-in: captures cmd/op1 then op2, answers rsp_delay cycles later
    int          rsp_delay = 1;
    logic        resp_en = 1'b1;
    int          inj_req = 0;
    int          inj_done = 0;
    logic [0:1]  inj_val = '0;
    int          ph = 0;
    int          cd = -1;
    logic [0:3]  rc;
    logic [0:31] ro1;
    logic [33:0] pend;

    // Responder runs 2 time units after each rising edge.
    always @(posedge c_clk) begin
        #2;
        port_resp  = '0;
        port_rdata = '0;
        if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0) begin
                port_resp  = pend[33:32];
                port_rdata = pend[31:0];
                cd = -1;
            end
        end
        if (inj_req != inj_done) begin
            port_resp  = inj_val;
            port_rdata = 32'hDEAD_BEEF;
            inj_done   = inj_done + 1;
        end
        if (ph == 1) begin
            pend = calc1_fn(rc, ro1, port_data);
            if (resp_en) cd = rsp_delay;
            ph = 0;
        end else if (port_cmd != 4'd0) begin
            rc  = port_cmd;
            ro1 = port_data;
            ph  = 1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    // Timeline model: offsets are falling edges since the accepting one.
    logic        busy = 1'b0;
    logic        nul = 1'b0;
    int          off = 0;
    int          lat = 0;
    int          rcnt = 0;
    logic        prev_cand = 1'b0;
    logic [3:0]  mcmd;
    logic [31:0] mop1, mop2;
    logic [1:0]  e_resp;
    logic [31:0] e_data;
    logic        e_to;

    task automatic model_step();
        logic [3:0]  ec;
        logic [31:0] ed;
        logic        ev, er;
        logic [33:0] r;
        if (reset) begin
            chk("rst_req_ready", 64'(req_ready), 64'(0));
            chk("rst_port_cmd", 64'(port_cmd), 64'(0));
            chk("rst_port_data", 64'(port_data), 64'(0));
            chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
            chk("rst_rsp_resp", 64'(rsp_resp), 64'(0));
            chk("rst_rsp_data", 64'(rsp_data), 64'(0));
            chk("rst_rsp_timeout", 64'(rsp_timeout), 64'(0));
            chk("rst_stray", 64'(stray_resp), 64'(0));
            busy = 1'b0;
            prev_cand = 1'b0;
            rcnt = 0;
            return;
        end
        if (rcnt < 3) rcnt++;
        if (busy) off++;
        ec = '0;
        ed = '0;
        if (busy && !nul && off == 1) begin
            ec = mcmd;
            ed = mop1;
        end else if (busy && !nul && off == 2) begin
            ed = mop2;
        end
        ev = busy && (off >= lat);
        er = (rcnt >= 2) && !busy;
        chk("m_port_cmd", 64'(port_cmd), 64'(ec));
        chk("m_port_data", 64'(port_data), 64'(ed));
        chk("m_req_ready", 64'(req_ready), 64'(er));
        chk("m_rsp_valid", 64'(rsp_valid), 64'(ev));
        chk("m_stray", 64'(stray_resp), 64'(prev_cand));
        if (ev) begin
            chk("m_rsp_resp", 64'(rsp_resp), 64'(e_resp));
            chk("m_rsp_data", 64'(rsp_data), 64'(e_data));
            chk("m_rsp_timeout", 64'(rsp_timeout), 64'(e_to));
        end else begin
            chk("m_timeout_low", 64'(rsp_timeout), 64'(0));
        end
        prev_cand = (port_resp != 2'd0) &&
                    !(busy && !nul && off >= 3 && off <= lat - 1);
        if (ev && rsp_ready) begin
            busy = 1'b0;
        end else if (!busy && er && req_valid) begin
            busy = 1'b1;
            off  = 0;
            mcmd = req_cmd;
            mop1 = req_op1;
            mop2 = req_op2;
            nul  = (req_cmd == 4'd0);
            if (nul) begin
                lat = 1;
                e_resp = 2'd0;
                e_data = '0;
                e_to = 1'b0;
            end else if (resp_en && rsp_delay >= 1 && rsp_delay <= T) begin
                r = calc1_fn(req_cmd, req_op1, req_op2);
                lat = 3 + rsp_delay;
                e_resp = r[33:32];
                e_data = (r[33:32] == 2'd1) ? r[31:0] : 32'd0;
                e_to = 1'b0;
            end else begin
                lat = 3 + T;
                e_resp = 2'd0;
                e_data = '0;
                e_to = 1'b1;
            end
        end
    endtask

    task automatic offer(input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b);
        @(posedge c_clk);
        #1;
        req_valid = 1'b1;
        req_cmd   = c;
        req_op1   = a;
        req_op2   = b;
    endtask

    task automatic wait_accept(input string nm);
        for (int i = 0; i < 40; i++) begin
            @(negedge c_clk);
            if (req_ready) begin
                @(posedge c_clk);
                #1;
                req_valid = 1'b0;
                return;
            end
        end
        req_valid = 1'b0;
        fail({nm, "_accept"});
    endtask

    task automatic get(input string nm, input logic [1:0] er,
                       input logic [31:0] ed, input logic et);
        for (int i = 0; i < 40; i++) begin
            @(negedge c_clk);
            if (rsp_valid) begin
                chk({nm, "_resp"}, 64'(rsp_resp), 64'(er));
                chk({nm, "_data"}, 64'(rsp_data), 64'(ed));
                chk({nm, "_timeout"}, 64'(rsp_timeout), 64'(et));
                return;
            end
        end
        fail({nm, "_rsp"});
    endtask

    task automatic run(input string nm, input logic [3:0] c,
                       input logic [31:0] a, input logic [31:0] b,
                       input int d, input logic [1:0] er,
                       input logic [31:0] ed, input logic et);
        rsp_delay = d;
        offer(c, a, b);
        wait_accept(nm);
        get(nm, er, ed, et);
    endtask

    initial begin
        fork
            begin : monitor
                forever begin
                    @(negedge c_clk);
                    model_step();
                end
            end
            begin : stimulus
                logic found;
                #1 reset = 1'b1;
                repeat (3) @(posedge c_clk);
                #1 reset = 1'b0;
                repeat (2) @(negedge c_clk);
                chk("ready_after_rst", 64'(req_ready), 64'(1));

                run("add", 4'd1, 32'h1, 32'h1FFF_FFFF, 1, 2'd1, 32'h2000_0000, 1'b0);
                run("add_ovf", 4'd1, 32'hFFFF_FFFF, 32'h1, 2, 2'd2, 32'h0, 1'b0);
                run("sub_neg", 4'd2, 32'h1, 32'hF, 3, 2'd2, 32'h0, 1'b0);
                run("bad3", 4'd3, 32'h5, 32'h6, 1, 2'd2, 32'h0, 1'b0);
                run("bad15", 4'd15, 32'h5, 32'h6, 2, 2'd2, 32'h0, 1'b0);
                run("shl", 4'd5, 32'h1, 32'd31, 1, 2'd1, 32'h8000_0000, 1'b0);
                run("shr", 4'd6, 32'h8000_0000, 32'd1, 4, 2'd1, 32'h4000_0000, 1'b0);

                resp_en = 1'b0;
                run("timeout", 4'd1, 32'h2, 32'h3, 1, 2'd0, 32'h0, 1'b1);
                resp_en = 1'b1;
                run("late_win", 4'd1, 32'h2, 32'h3, T, 2'd1, 32'h5, 1'b0);

                @(posedge c_clk);
                #1;
                inj_val = 2'd1;
                inj_req = inj_req + 1;
                @(posedge c_clk);
                @(negedge c_clk);
                chk("stray_idle", 64'(stray_resp), 64'(1));
                chk("stray_no_valid", 64'(rsp_valid), 64'(0));
                @(negedge c_clk);
                chk("stray_clear", 64'(stray_resp), 64'(0));

                rsp_ready = 1'b0;
                run("hold", 4'd1, 32'd10, 32'd20, 1, 2'd1, 32'd30, 1'b0);
                repeat (2) @(negedge c_clk);
                offer(4'd2, 32'd9, 32'd4);
                repeat (3) @(negedge c_clk);
                chk("hold_ready", 64'(req_ready), 64'(0));
                chk("hold_data", 64'(rsp_data), 64'(30));
                chk("hold_valid", 64'(rsp_valid), 64'(1));
                @(posedge c_clk);
                #1 rsp_ready = 1'b1;
                wait_accept("hold2");
                get("hold2", 2'd1, 32'd5, 1'b0);

                run("null", 4'd0, 32'h1234, 32'h5678, 1, 2'd0, 32'h0, 1'b0);

                rsp_delay = 6;
                offer(4'd1, 32'd7, 32'd8);
                wait_accept("mid_rst");
                repeat (3) @(posedge c_clk);
                #1 reset = 1'b1;
                @(negedge c_clk);
                chk("mid_rst_valid", 64'(rsp_valid), 64'(0));
                chk("mid_rst_ready", 64'(req_ready), 64'(0));
                repeat (2) @(posedge c_clk);
                #1 reset = 1'b0;
                found = 1'b0;
                for (int i = 0; i < 20 && !found; i++) begin
                    @(negedge c_clk);
                    if (stray_resp) found = 1'b1;
                end
                chk("late_stray", 64'(found), 64'(1));
                run("after_rst", 4'd2, 32'd9, 32'd4, 1, 2'd1, 32'd5, 1'b0);
                repeat (3) @(negedge c_clk);
            end
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
